// File: rtl/tff_bank_if.sv
// Control and status bundle for the tff_bank toggle flip-flop bank.
// The master drives enable, mode, toggle mask and load data.
// The slave (the bank) returns the registered state and status flags.
interface tff_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             changed;

    modport master (
        output en,
        output mode,
        output T,
        output D,
        input  Q,
        input  tc,
        input  changed
    );

    modport slave (
        input  en,
        input  mode,
        input  T,
        input  D,
        output Q,
        output tc,
        output changed
    );
endinterface

// File: rtl/tff_bank.sv
// tff_bank: a WIDTH-bit bank of T flip-flops that share one clock and one
// synchronous clear.
//
// Every operating mode is expressed as a per-bit toggle vector applied to the
// current state (q_next = q ^ toggle):
//   - toggle: the toggle vector is the caller's mask T
//   - load:   the toggle vector is q ^ D, so the bits that differ flip
//   - up:     bit i toggles when all lower bits are 1 (a T-FF ripple chain)
//   - down:   bit i toggles when all lower bits are 0
// Because of this form, "changed" is the OR of the toggle vector. It is
// derived from the same value that produces the next state, so it cannot
// disagree with Q.
module tff_bank #(
    parameter int             WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter bit             WRAP  = 1'b1
) (
    input  logic      clk,
    input  logic      clear,
    tff_bank_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    // A saturating counter suppresses the toggle at the terminal value.
    localparam bit SATURATE = (WRAP == 1'b0);

    // Registered state.
    logic [WIDTH-1:0] q_reg;
    logic             tc_reg;
    logic             changed_reg;

    // Next-state signals.
    logic [WIDTH-1:0] tog_next;
    logic             tc_next;
    logic             changed_next;

    // Count toggle enables and terminal detection.
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] down_tog;
    logic             all_ones;
    logic             all_zeros;
    mode_e            mode;

    assign mode = mode_e'(bus.mode);

    // T-FF counter chain. Bit 0 always toggles. Bit gi toggles in the up
    // direction when all bits below it are 1. It toggles in the down
    // direction when all bits below it are 0. Each bit reduces its own lower
    // slice directly instead of using a rippled running AND. This keeps the
    // logic free of a self-referencing vector.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            if (gi == 0) begin : g_lsb
                assign up_tog[gi]   = 1'b1;
                assign down_tog[gi] = 1'b1;
            end else begin : g_upper
                assign up_tog[gi]   = &q_reg[gi-1:0];
                assign down_tog[gi] = ~|q_reg[gi-1:0];
            end
        end
    endgenerate

    // Terminal values. Up terminates at all-ones and down terminates at zero.
    // For WIDTH=1 these reduce to Q==1 for up and Q==0 for down.
    assign all_ones  = &q_reg;
    assign all_zeros = ~|q_reg;

    // Select the toggle vector and terminal-count flag for the current mode.
    always_comb begin
        tog_next     = '0;
        tc_next      = 1'b0;
        if (bus.en) begin
            unique case (mode)
                MODE_TOGGLE: begin
                    tog_next = bus.T;
                end
                MODE_LOAD: begin
                    tog_next = q_reg ^ bus.D;
                end
                MODE_UP: begin
                    tc_next  = all_ones;
                    tog_next = (SATURATE && all_ones) ? '0 : up_tog;
                end
                MODE_DOWN: begin
                    tc_next  = all_zeros;
                    tog_next = (SATURATE && all_zeros) ? '0 : down_tog;
                end
                default: begin
                    tog_next = '0;
                end
            endcase
        end
        changed_next = |tog_next;
    end

    // Bank state plus status flags. Clear has priority over everything else.
    // When en=0, tog_next is zero, so Q holds and both flags drop.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_reg       <= INIT;
            tc_reg      <= 1'b0;
            changed_reg <= 1'b0;
        end else begin
            q_reg       <= q_reg ^ tog_next;
            tc_reg      <= tc_next;
            changed_reg <= changed_next;
        end
    end

    assign bus.Q       = q_reg;
    assign bus.tc      = tc_reg;
    assign bus.changed = changed_reg;

endmodule

// File: tb/tb_tff_bank.sv
// Directed testbench for tff_bank. Four instances cover the parameter
// corners:
//   a: WIDTH=4, INIT=5, WRAP=1
//   b: WIDTH=4, INIT=0, WRAP=0 (saturating)
//   c: WIDTH=8, INIT=0, WRAP=1
//   d: WIDTH=1, INIT=0, WRAP=1
module tb_tff_bank;

    logic clk;
    logic clear_a, clear_b, clear_c, clear_d;
    int   checks;
    int   failures;

    tff_bank_if #(.WIDTH(4)) a_if ();
    tff_bank_if #(.WIDTH(4)) b_if ();
    tff_bank_if #(.WIDTH(8)) c_if ();
    tff_bank_if #(.WIDTH(1)) d_if ();

    tff_bank #(.WIDTH(4), .INIT(4'h5), .WRAP(1'b1)) dut_a (
        .clk(clk), .clear(clear_a), .bus(a_if)
    );
    tff_bank #(.WIDTH(4), .INIT(4'h0), .WRAP(1'b0)) dut_b (
        .clk(clk), .clear(clear_b), .bus(b_if)
    );
    tff_bank #(.WIDTH(8), .INIT(8'h00), .WRAP(1'b1)) dut_c (
        .clk(clk), .clear(clear_c), .bus(c_if)
    );
    tff_bank #(.WIDTH(1), .INIT(1'b0), .WRAP(1'b1)) dut_d (
        .clk(clk), .clear(clear_d), .bus(d_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_if.en = 1'b1; a_if.mode = 2'b10; a_if.T = '0; a_if.D = '0;
        clear_a = 1'b1;
        step();
        checks++;
        if (a_if.Q !== 4'h5 || a_if.tc !== 1'b0 || a_if.changed !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got Q=%h tc=%b ch=%b exp Q=5 tc=0 ch=0",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        clear_a = 1'b0;
        step();
        checks++;
        if (a_if.Q !== 4'h6 || a_if.changed !== 1'b1 || a_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got Q=%h tc=%b ch=%b exp Q=6 tc=0 ch=1",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        $display("test_reset done");
    endtask

    task automatic test_toggle();
        a_if.en = 1'b1; a_if.mode = 2'b01; a_if.D = 4'hA;
        step();
        a_if.mode = 2'b00; a_if.T = 4'b0110;
        step();
        checks++;
        if (a_if.Q !== 4'hC || a_if.changed !== 1'b1 || a_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL toggle_mask got Q=%h tc=%b ch=%b exp Q=c tc=0 ch=1",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        a_if.T = 4'h0;
        step();
        checks++;
        if (a_if.Q !== 4'hC || a_if.changed !== 1'b0) begin
            failures++;
            $display("FAIL toggle_zero got Q=%h ch=%b exp Q=c ch=0", a_if.Q, a_if.changed);
        end
        a_if.en = 1'b0; a_if.T = 4'hF;
        step();
        checks++;
        if (a_if.Q !== 4'hC || a_if.changed !== 1'b0 || a_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL toggle_en_off got Q=%h tc=%b ch=%b exp Q=c tc=0 ch=0",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        a_if.en = 1'b1; a_if.T = 4'h0;
        $display("test_toggle done");
    endtask

    task automatic test_wrap_count();
        logic [3:0] exp_q  [5];
        logic       exp_tc [5];
        exp_q  = '{4'hF, 4'h0, 4'h1, 4'h0, 4'hF};
        exp_tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        a_if.en = 1'b1; a_if.mode = 2'b01; a_if.D = 4'hE;
        step();
        checks++;
        if (a_if.Q !== 4'hE) begin
            failures++;
            $display("FAIL wrap_load got Q=%h exp Q=e", a_if.Q);
        end
        for (int i = 0; i < 5; i++) begin
            a_if.mode = (i < 3) ? 2'b10 : 2'b11;
            step();
            checks++;
            if (a_if.Q !== exp_q[i] || a_if.tc !== exp_tc[i] || a_if.changed !== 1'b1) begin
                failures++;
                $display("FAIL wrap_step%0d got Q=%h tc=%b ch=%b exp Q=%h tc=%b ch=1",
                         i, a_if.Q, a_if.tc, a_if.changed, exp_q[i], exp_tc[i]);
            end
        end
        $display("test_wrap_count done");
    endtask

    task automatic test_saturate();
        logic       exp_tc [4];
        logic       exp_ch [4];
        exp_tc = '{1'b0, 1'b1, 1'b1, 1'b1};
        exp_ch = '{1'b1, 1'b0, 1'b0, 1'b0};
        clear_b = 1'b0;
        b_if.en = 1'b1; b_if.mode = 2'b01; b_if.D = 4'hE; b_if.T = '0;
        step();
        b_if.mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (b_if.Q !== 4'hF || b_if.tc !== exp_tc[i] || b_if.changed !== exp_ch[i]) begin
                failures++;
                $display("FAIL sat_up%0d got Q=%h tc=%b ch=%b exp Q=f tc=%b ch=%b",
                         i, b_if.Q, b_if.tc, b_if.changed, exp_tc[i], exp_ch[i]);
            end
        end
        b_if.en = 1'b0;
        step();
        checks++;
        if (b_if.Q !== 4'hF || b_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL sat_en_off got Q=%h tc=%b exp Q=f tc=0", b_if.Q, b_if.tc);
        end
        b_if.en = 1'b1; b_if.mode = 2'b01; b_if.D = 4'h0;
        step();
        b_if.mode = 2'b11;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (b_if.Q !== 4'h0 || b_if.tc !== 1'b1 || b_if.changed !== 1'b0) begin
                failures++;
                $display("FAIL sat_down%0d got Q=%h tc=%b ch=%b exp Q=0 tc=1 ch=0",
                         i, b_if.Q, b_if.tc, b_if.changed);
            end
        end
        $display("test_saturate done");
    endtask

    task automatic test_mid_count_clear();
        c_if.en = 1'b1; c_if.mode = 2'b10; c_if.T = '0; c_if.D = '0;
        clear_c = 1'b1;
        step();
        clear_c = 1'b0;
        for (int i = 0; i < 127; i++) step();
        checks++;
        if (c_if.Q !== 8'h7F || c_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL count_to_7f got Q=%h tc=%b exp Q=7f tc=0", c_if.Q, c_if.tc);
        end
        clear_c = 1'b1;
        step();
        checks++;
        if (c_if.Q !== 8'h00 || c_if.tc !== 1'b0 || c_if.changed !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear got Q=%h tc=%b ch=%b exp Q=00 tc=0 ch=0",
                     c_if.Q, c_if.tc, c_if.changed);
        end
        clear_c = 1'b0;
        c_if.mode = 2'b01; c_if.D = 8'h7F;
        step();
        c_if.mode = 2'b10;
        step();
        checks++;
        if (c_if.Q !== 8'h80 || c_if.tc !== 1'b0 || c_if.changed !== 1'b1) begin
            failures++;
            $display("FAIL carry_7f got Q=%h tc=%b ch=%b exp Q=80 tc=0 ch=1",
                     c_if.Q, c_if.tc, c_if.changed);
        end
        c_if.mode = 2'b01; c_if.D = 8'hFF;
        step();
        c_if.mode = 2'b10;
        step();
        checks++;
        if (c_if.Q !== 8'h00 || c_if.tc !== 1'b1) begin
            failures++;
            $display("FAIL wrap_ff got Q=%h tc=%b exp Q=00 tc=1", c_if.Q, c_if.tc);
        end
        $display("test_mid_count_clear done");
    endtask

    task automatic test_load_equal();
        a_if.en = 1'b1; a_if.mode = 2'b01; a_if.D = 4'h9;
        step();
        step();
        checks++;
        if (a_if.Q !== 4'h9 || a_if.changed !== 1'b0 || a_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL load_equal got Q=%h tc=%b ch=%b exp Q=9 tc=0 ch=0",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        a_if.D = 4'h3;
        step();
        checks++;
        if (a_if.Q !== 4'h3 || a_if.changed !== 1'b1 || a_if.tc !== 1'b0) begin
            failures++;
            $display("FAIL load_new got Q=%h tc=%b ch=%b exp Q=3 tc=0 ch=1",
                     a_if.Q, a_if.tc, a_if.changed);
        end
        $display("test_load_equal done");
    endtask

    task automatic test_width1();
        logic [1:0] modes  [4];
        logic       exp_q  [4];
        logic       exp_tc [4];
        modes  = '{2'b10, 2'b10, 2'b11, 2'b11};
        exp_q  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_tc = '{1'b0, 1'b1, 1'b1, 1'b0};
        d_if.en = 1'b1; d_if.mode = 2'b10; d_if.T = '0; d_if.D = '0;
        clear_d = 1'b1;
        step();
        clear_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_if.mode = modes[i];
            step();
            checks++;
            if (d_if.Q !== exp_q[i] || d_if.tc !== exp_tc[i]) begin
                failures++;
                $display("FAIL w1_step%0d got Q=%b tc=%b exp Q=%b tc=%b",
                         i, d_if.Q, d_if.tc, exp_q[i], exp_tc[i]);
            end
        end
        $display("test_width1 done");
    endtask

    initial begin
        checks = 0; failures = 0;
        clear_a = 1'b1; clear_b = 1'b1; clear_c = 1'b1; clear_d = 1'b1;
        a_if.en = 1'b0; a_if.mode = 2'b00; a_if.T = '0; a_if.D = '0;
        b_if.en = 1'b0; b_if.mode = 2'b00; b_if.T = '0; b_if.D = '0;
        c_if.en = 1'b0; c_if.mode = 2'b00; c_if.T = '0; c_if.D = '0;
        d_if.en = 1'b0; d_if.mode = 2'b00; d_if.T = '0; d_if.D = '0;
        step();
        test_reset();
        test_toggle();
        test_wrap_count();
        test_saturate();
        test_mid_count_clear();
        test_load_equal();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
